cpu_control_unit: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit CPU datapath. It fetches 16-bit instructions from instruction memory and owns the 6-bit program counter. For every instruction it decodes and drives the datapath control word (DA, AA, BA, FS, MB, resultSource, RW, MW) through a fixed state sequence. It resolves branches and jumps from the datapath's Dout/Aout read-back values.

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/cpu_control_unit_if.sv | 26 ++
 rtl/cpu_decoder.sv | 27 ++
 rtl/cpu_control_unit.sv | 92 +++++++++
 tb/tb_cpu_control_unit.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit CPU control path.
package cpu_pkg;

  localparam int CPU_ADDR_W = 4;
  localparam int CPU_PC_W   = 6;
  localparam int CPU_FS_W   = 3;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_SLA  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LD   = 4'd9;
  localparam logic [3:0] OP_ST   = 4'd10;
  localparam logic [3:0] OP_LDI  = 4'd11;
  localparam logic [3:0] OP_BZ   = 4'd12;
  localparam logic [3:0] OP_BNZ  = 4'd13;
  localparam logic [3:0] OP_JAL  = 4'd14;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [CPU_FS_W-1:0] FS_ADD = 3'd0;
  localparam logic [CPU_FS_W-1:0] FS_SUB = 3'd1;
  localparam logic [CPU_FS_W-1:0] FS_AND = 3'd2;
  localparam logic [CPU_FS_W-1:0] FS_OR  = 3'd3;
  localparam logic [CPU_FS_W-1:0] FS_XOR = 3'd4;
  localparam logic [CPU_FS_W-1:0] FS_NOT = 3'd5;
  localparam logic [CPU_FS_W-1:0] FS_SLA = 3'd6;
  localparam logic [CPU_FS_W-1:0] FS_SRA = 3'd7;

  localparam logic [1:0] SOURCE_F         = 2'd0;
  localparam logic [1:0] SOURCE_PC        = 2'd1;
  localparam logic [1:0] SOURCE_RAM       = 2'd2;
  localparam logic [1:0] SOURCE_IMMEDIATE = 2'd3;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMWAIT, WB, HALT} state_t;

  typedef enum logic [2:0] {CLS_ALU, CLS_LD, CLS_ST, CLS_BR, CLS_JAL, CLS_HALT} iclass_t;

  typedef struct packed {
    logic [CPU_FS_W-1:0] fs;
    logic                mb;
    logic [1:0]          rsrc;
    logic                wr;    // instruction writes R[DA] in WB
    logic                brnz;  // branch sense: 1 = BNZ
    iclass_t             cls;
  } ctrl_t;

endpackage

// File: rtl/cpu_control_unit_if.sv
// Control-unit <-> datapath/instruction-memory bundle.
interface cpu_control_unit_if #(
  parameter int ADDR_W = 4,
  parameter int PC_W   = 6,
  parameter int FS_W   = 3
);
  logic [PC_W-1:0]   instr_addr;
  logic [15:0]       instr_data;
  logic [ADDR_W-1:0] DA, AA, BA;
  logic [FS_W-1:0]   FS;
  logic              MB;
  logic [1:0]        resultSource;
  logic              RW, MW;
  logic [PC_W-1:0]   PC;
  logic [15:0]       Dout, Aout;
  logic              halted;

  modport master (
    output instr_addr, DA, AA, BA, FS, MB, resultSource, RW, MW, PC, halted,
    input  instr_data, Dout, Aout
  );
  modport slave (
    input  instr_addr, DA, AA, BA, FS, MB, resultSource, RW, MW, PC, halted,
    output instr_data, Dout, Aout
  );
endinterface

// File: rtl/cpu_decoder.sv
// Combinational opcode -> control word and instruction class.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [3:0] op,
  output ctrl_t      cw
);
  always_comb begin
    cw     = '0;
    cw.cls = CLS_ALU;
    if (!op[3]) begin
      cw.fs = op[2:0];
      cw.wr = 1'b1;
    end else begin
      case (op)
        OP_ADDI: begin cw.fs = FS_ADD; cw.mb = 1'b1; cw.wr = 1'b1; end
        OP_LD:   begin cw.rsrc = SOURCE_RAM; cw.wr = 1'b1; cw.cls = CLS_LD; end
        OP_ST:   cw.cls = CLS_ST;
        OP_LDI:  begin cw.rsrc = SOURCE_IMMEDIATE; cw.wr = 1'b1; end
        OP_BZ:   cw.cls = CLS_BR;
        OP_BNZ:  begin cw.cls = CLS_BR; cw.brnz = 1'b1; end
        OP_JAL:  begin cw.rsrc = SOURCE_PC; cw.wr = 1'b1; cw.cls = CLS_JAL; end
        default: cw.cls = CLS_HALT;
      endcase
    end
  end
endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle sequencer: owns PC and IR, drives the datapath control word.
// Optional single-step mode: define CPU_CTRL_SINGLE_STEP_EN.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int PC_W   = CPU_PC_W,
  parameter int FS_W   = CPU_FS_W
) (
  input  logic clk,
  input  logic reset,
`ifdef CPU_CTRL_SINGLE_STEP_EN
  input  logic step,
`endif
  cpu_control_unit_if.master bus
);
  state_t          state, state_d;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc, pc_d, pc_inc;
  ctrl_t           cw;
  logic            go, taken;

  cpu_decoder u_dec (.op(ir[15:12]), .cw(cw));

`ifdef CPU_CTRL_SINGLE_STEP_EN
  logic step_q;
  always_ff @(posedge clk) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end
  assign go = step & ~step_q;
`else
  assign go = 1'b1;
`endif

  assign pc_inc = pc + 1'b1;
  assign taken  = cw.brnz ? (bus.Dout != 16'd0) : (bus.Dout == 16'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (state == DECODE) ir <= bus.instr_data;
    end
  end

  always_comb begin
    state_d = state;
    pc_d    = pc;
    case (state)
      FETCH:   if (go) state_d = DECODE;
      DECODE:  state_d = EXEC;
      EXEC: begin
        case (cw.cls)
          CLS_LD:   state_d = MEMWAIT;
          CLS_ST:   begin pc_d = pc_inc; state_d = FETCH; end
          // low PC_W bits of the 8-bit offset give the same modular sum as sext8
          CLS_BR:   begin pc_d = pc_inc + (taken ? ir[PC_W-1:0] : '0); state_d = FETCH; end
          CLS_HALT: state_d = HALT;
          default:  state_d = WB;
        endcase
      end
      MEMWAIT: state_d = WB;
      WB: begin
        pc_d    = (cw.cls == CLS_JAL) ? bus.Aout[PC_W-1:0] : pc_inc;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Enables are gated by reset so a reset landing in WB/EXEC suppresses the write.
  assign bus.RW           = reset && (state == WB) && cw.wr;
  assign bus.MW           = reset && (state == EXEC) && (cw.cls == CLS_ST);
  assign bus.instr_addr   = pc;
  assign bus.PC           = pc;
  assign bus.DA           = ir[8 +: ADDR_W];
  assign bus.AA           = ir[4 +: ADDR_W];
  assign bus.BA           = ir[0 +: ADDR_W];
  assign bus.FS           = cw.fs;
  assign bus.MB           = cw.mb;
  assign bus.resultSource = cw.rsrc;
  assign bus.halted       = (state == HALT);

  logic unused_aout;
  assign unused_aout = &{1'b0, bus.Aout[15:PC_W]};
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: per-instruction vector table plus reset/HALT sequences.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic step_r = 1'b0;
  logic [15:0] imem [64];
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cpu_control_unit_if #(.ADDR_W(4), .PC_W(6), .FS_W(3)) bus ();

  cpu_control_unit #(.ADDR_W(4), .PC_W(6), .FS_W(3)) dut (
    .clk(clk),
    .reset(reset),
`ifdef CPU_CTRL_SINGLE_STEP_EN
    .step(step_r),
`endif
    .bus(bus)
  );

`ifndef CPU_CTRL_SINGLE_STEP_EN
  logic unused_step;
  assign unused_step = step_r;
`endif

  always @(posedge clk) bus.instr_data <= imem[bus.instr_addr];

  typedef struct {
    logic [15:0] instr;
    logic [15:0] dout;
    logic [15:0] aout;
    int cyc, pc, rw, mw, rsrc, fs, mb, da;
  } vec_t;

  vec_t vt [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called at a negedge with the FSM in FETCH; runs one instruction to the next FETCH.
  task automatic run(input vec_t v, input int idx);
    int n = 0, rw_c = 0, mw_c = 0, both = 0;
    logic [1:0] rs;
    logic [2:0] fs;
    logic mb;
    logic [3:0] da;
    imem[bus.instr_addr] = v.instr;
    bus.Dout = v.dout;
    bus.Aout = v.aout;
    step_r = 1'b1;
    do begin
      if (bus.RW === 1'b1) rw_c++;
      if (bus.MW === 1'b1) mw_c++;
      if (bus.RW === 1'b1 && bus.MW === 1'b1) both++;
      rs = bus.resultSource; fs = bus.FS; mb = bus.MB; da = bus.DA;
      @(negedge clk);
      step_r = 1'b0;
      n++;
    end while (dut.state != FETCH && n < 12);
    chk($sformatf("v%0d cycles", idx), n, v.cyc);
    chk($sformatf("v%0d next_pc", idx), bus.PC, v.pc);
    chk($sformatf("v%0d rw_count", idx), rw_c, v.rw);
    chk($sformatf("v%0d mw_count", idx), mw_c, v.mw);
    chk($sformatf("v%0d rw_mw_overlap", idx), both, 0);
    chk($sformatf("v%0d resultSource", idx), rs, v.rsrc);
    chk($sformatf("v%0d FS", idx), fs, v.fs);
    chk($sformatf("v%0d MB", idx), mb, v.mb);
    chk($sformatf("v%0d DA", idx), da, v.da);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec_t hv;
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    bus.Dout = '0;
    bus.Aout = '0;
    //          instr     dout   aout     cyc pc rw mw rs fs mb da
    vt[0]  = '{16'hB105, 16'h0, 16'h0000, 4,  1, 1, 0, 3, 0, 0, 1};
    vt[1]  = '{16'h0211, 16'h0, 16'h0000, 4,  2, 1, 0, 0, 0, 0, 2};
    vt[2]  = '{16'h8312, 16'h0, 16'h0000, 4,  3, 1, 0, 0, 0, 1, 3};
    vt[3]  = '{16'hA010, 16'h0, 16'h0010, 3,  4, 0, 1, 0, 0, 0, 0};
    vt[4]  = '{16'h1421, 16'h0, 16'h0000, 4,  5, 1, 0, 0, 1, 0, 4};
    vt[5]  = '{16'hC0FE, 16'h0, 16'h0000, 3,  4, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{16'h1421, 16'h0, 16'h0000, 4,  5, 1, 0, 0, 1, 0, 4};
    vt[7]  = '{16'hC0FE, 16'h7, 16'h0000, 3,  6, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{16'h9510, 16'h0, 16'h0010, 5,  7, 1, 0, 2, 0, 0, 5};
    vt[9]  = '{16'hD002, 16'h1, 16'h0000, 3, 10, 0, 0, 0, 0, 0, 0};
    vt[10] = '{16'hEF30, 16'h0, 16'h0021, 4, 33, 1, 0, 1, 0, 0, 15};
    vt[11] = '{16'h5620, 16'h0, 16'h0000, 4, 34, 1, 0, 0, 5, 0, 6};
    vt[12] = '{16'hE000, 16'h0, 16'h003F, 4, 63, 1, 0, 1, 0, 0, 0};
    vt[13] = '{16'hD010, 16'h0, 16'h0000, 3,  0, 0, 0, 0, 0, 0, 0};

    @(negedge clk);
    @(negedge clk);
    chk("reset PC", bus.PC, 0);
    chk("reset RW", bus.RW, 0);
    chk("reset MW", bus.MW, 0);
    chk("reset halted", bus.halted, 0);
    chk("reset ctrl", {bus.DA, bus.AA, bus.BA, bus.FS, bus.MB, bus.resultSource}, 0);
    chk("reset state", dut.state, FETCH);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) run(vt[i], i);

    // Reset during MEMWAIT of an LD: write abandoned, restart at PC 0.
    imem[0] = 16'h9510;
    bus.Aout = 16'h0010;
    step_r = 1'b1;
    @(negedge clk); step_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("memwait reached", dut.state, MEMWAIT);
    reset = 1'b0;
    chk("memwait RW", bus.RW, 0);
    @(negedge clk);
    chk("post-reset state", dut.state, FETCH);
    chk("post-reset PC", bus.PC, 0);
    chk("post-reset RW", bus.RW, 0);
    reset = 1'b1;

    // Reset landing in WB: RW must drop immediately and PC must not advance.
    imem[0] = 16'hB105;
    step_r = 1'b1;
    @(negedge clk); step_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("wb reached", dut.state, WB);
    chk("wb RW before reset", bus.RW, 1);
    reset = 1'b0;
    #1;
    chk("wb RW under reset", bus.RW, 0);
    @(negedge clk);
    chk("wb reset PC", bus.PC, 0);
    reset = 1'b1;

    // LDI then HALT: halted sticks and PC freezes at 1.
    imem[1] = 16'hF000;
    hv = '{16'hB105, 16'h0, 16'h0000, 4, 1, 1, 0, 3, 0, 0, 1};
    run(hv, 14);
    step_r = 1'b1;
    @(negedge clk); step_r = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("halt c%0d halted", c), bus.halted, 1);
      chk($sformatf("halt c%0d PC", c), bus.PC, 1);
      chk($sformatf("halt c%0d RW|MW", c), bus.RW | bus.MW, 0);
      @(negedge clk);
    end
    do_reset();
    chk("halt cleared by reset", bus.halted, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
